eco32_cpu_core: RTL and testbench

- Reduced ECO32-compatible multi-cycle CPU core: fetches 32-bit instructions over a simple wait-state bus and executes register/immediate ALU instructions on a 32×32 register file.
- Kernel direct-mapped address translation only; no TLB, no loads/stores, no branches, no interrupts or exceptions.
- Sits between the system bus and the rest of the SoC; it is the only bus master.

---
 rtl/eco32_cpu_core.sv | 239 +++++++++++++++++++++++
 tb/tb_eco32_cpu_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eco32_cpu_core.sv
// eco32_cpu_core
// Reduced ECO32-compatible multi-cycle CPU core. Every instruction is fetched
// over a simple wait-state bus and then executed as a register/immediate ALU
// operation on a 32x32 register file. Only the kernel direct-mapped address
// window is translated; there are no loads/stores, branches or exceptions.
//
// Ports:
//   clock         system clock, all state changes on the rising edge
//   reset         synchronous, active-low reset
//   busEnable     registered bus request
//   busSize       transfer size (00 byte, 01 halfword, 10 word), always word
//   busWrite      write strobe, always 0 (instruction fetches only)
//   busAddress    physical fetch address
//   busWriteData  write data, constant 0
//   busReadData   instruction word, taken when busEnable=1 and busWait=0
//   busWait       slave stall request
//   interrupts    reserved interrupt lines, ignored
module eco32_cpu_core #(
    parameter logic [31:0] RESET_PC    = 32'hE0000000,
    parameter logic [7:0]  BUS_TIMEOUT = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    output logic        busEnable,
    output logic [1:0]  busSize,
    output logic        busWrite,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    input  logic [31:0] busReadData,
    input  logic        busWait,
    input  logic [15:0] interrupts
);

    typedef enum logic [2:0] {
        RESET                                    = 3'd0,
        BEGIN_INSTRUCTION                        = 3'd1,
        TRANSLATE_INSTRUCTION_ADDRESS            = 3'd2,
        INTERPRET_TRANSLATED_INSTRUCTION_ADDRESS = 3'd3,
        FETCH_INSTRUCTION                        = 3'd4,
        DECODE_INSTRUCTION                       = 3'd5,
        COMPUTE_ALU_OPERATOR                     = 3'd6,
        HALT                                     = 3'd7
    } stateType;

    // Opcodes with the immediate bit (bit 0) cleared; odd opcodes are the
    // immediate forms of the same operation.
    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_AND = 6'h10;
    localparam logic [5:0] OP_OR  = 6'h12;
    localparam logic [5:0] OP_XOR = 6'h14;
    localparam logic [5:0] OP_XNR = 6'h16;
    localparam logic [5:0] OP_SLL = 6'h18;
    localparam logic [5:0] OP_SLR = 6'h1A;
    localparam logic [5:0] OP_SAR = 6'h1C;

    stateType    state;
    stateType    stateNext;

    logic [31:0] programCounter;
    logic [31:0] processorStatusWordValue;
    logic [31:0] exceptionReturnAddressRegister;
    logic [31:0] virtualAddress;
    logic [31:0] currentInstruction;
    logic [31:0] leftOperandValue;
    logic [31:0] rightOperandValue;
    logic [31:0] aluResult;
    logic [7:0]  busTimeoutCounter;
    logic        mmuAffectRandomIndexCounter;

    logic [31:0] registerFile [0:31];

    logic [31:0] physicalAddress;
    logic [5:0]  opcode;
    logic [5:0]  baseOpcode;
    logic [4:0]  regS;
    logic [4:0]  regT;
    logic [4:0]  regD;
    logic [15:0] immediate;
    logic        isImmediate;
    logic        isValidOp;
    logic        isSignedImmediate;
    logic [4:0]  destReg;
    logic [31:0] extendedImmediate;
    logic [31:0] regSValue;
    logic [31:0] regTValue;
    logic [4:0]  shiftAmount;
    logic        regWriteEnable;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    assign opcode     = currentInstruction[31:26];
    assign regS       = currentInstruction[25:21];
    assign regT       = currentInstruction[20:16];
    assign regD       = currentInstruction[15:11];
    assign immediate  = currentInstruction[15:0];
    assign baseOpcode = {opcode[5:1], 1'b0};
    assign isImmediate = opcode[0];
    assign isValidOp  = (opcode <= 6'h03) || ((opcode >= 6'h10) && (opcode <= 6'h1D));
    // Only ADDI/SUBI sign-extend; logical and shift immediates zero-extend.
    assign isSignedImmediate = (opcode[5:2] == 4'b0000);
    assign extendedImmediate = isSignedImmediate ? {{16{immediate[15]}}, immediate}
                                                 : {16'h0000, immediate};
    assign destReg    = isImmediate ? regT : regD;
    assign regSValue  = (regS == 5'd0) ? 32'h0 : registerFile[regS];
    assign regTValue  = (regT == 5'd0) ? 32'h0 : registerFile[regT];
    assign regWriteEnable = isValidOp && (destReg != 5'd0);

    // Kernel direct-mapped window: C0000000..FFFFFFFF maps to 00000000..3FFFFFFF.
    assign physicalAddress = (virtualAddress >= 32'hC0000000)
                           ? {2'b00, virtualAddress[29:0]} : virtualAddress;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign shiftAmount = rightOperandValue[4:0];

    always_comb begin
        aluResult = 32'h0;
        case (baseOpcode)
            OP_ADD:  aluResult = leftOperandValue + rightOperandValue;
            OP_SUB:  aluResult = leftOperandValue - rightOperandValue;
            OP_AND:  aluResult = leftOperandValue & rightOperandValue;
            OP_OR:   aluResult = leftOperandValue | rightOperandValue;
            OP_XOR:  aluResult = leftOperandValue ^ rightOperandValue;
            OP_XNR:  aluResult = ~(leftOperandValue ^ rightOperandValue);
            OP_SLL:  aluResult = leftOperandValue << shiftAmount;
            OP_SLR:  aluResult = leftOperandValue >> shiftAmount;
            OP_SAR:  aluResult = 32'($signed(leftOperandValue) >>> shiftAmount);
            default: aluResult = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RESET;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RESET:                                    stateNext = BEGIN_INSTRUCTION;
            BEGIN_INSTRUCTION:                        stateNext = TRANSLATE_INSTRUCTION_ADDRESS;
            TRANSLATE_INSTRUCTION_ADDRESS:            stateNext = INTERPRET_TRANSLATED_INSTRUCTION_ADDRESS;
            INTERPRET_TRANSLATED_INSTRUCTION_ADDRESS: stateNext = FETCH_INSTRUCTION;
            FETCH_INSTRUCTION: begin
                if (!busWait) begin
                    stateNext = DECODE_INSTRUCTION;
                end else if (busTimeoutCounter == 8'h00) begin
                    stateNext = HALT;
                end
            end
            DECODE_INSTRUCTION:                       stateNext = COMPUTE_ALU_OPERATOR;
            COMPUTE_ALU_OPERATOR:                     stateNext = BEGIN_INSTRUCTION;
            HALT:                                     stateNext = HALT;
            default:                                  stateNext = RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and bus registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            programCounter                 <= RESET_PC;
            processorStatusWordValue       <= 32'h0;
            exceptionReturnAddressRegister <= 32'h0;
            virtualAddress                 <= 32'h0;
            currentInstruction             <= 32'h0;
            leftOperandValue               <= 32'h0;
            rightOperandValue              <= 32'h0;
            busTimeoutCounter              <= BUS_TIMEOUT;
            mmuAffectRandomIndexCounter    <= 1'b0;
            busEnable                      <= 1'b0;
            busWrite                       <= 1'b0;
            busSize                        <= 2'b10;
            busAddress                     <= 32'h0;
        end else begin
            case (state)
                BEGIN_INSTRUCTION: begin
                    exceptionReturnAddressRegister <= programCounter;
                    virtualAddress                 <= programCounter;
                    mmuAffectRandomIndexCounter    <= 1'b1;
                end
                TRANSLATE_INSTRUCTION_ADDRESS: begin
                    mmuAffectRandomIndexCounter <= 1'b0;
                end
                INTERPRET_TRANSLATED_INSTRUCTION_ADDRESS: begin
                    busAddress        <= physicalAddress;
                    busEnable         <= 1'b1;
                    busWrite          <= 1'b0;
                    busSize           <= 2'b10;
                    busTimeoutCounter <= BUS_TIMEOUT;
                end
                FETCH_INSTRUCTION: begin
                    if (!busWait) begin
                        currentInstruction <= busReadData;
                        busEnable          <= 1'b0;
                    end else if (busTimeoutCounter == 8'h00) begin
                        busEnable <= 1'b0;
                    end else begin
                        busTimeoutCounter <= busTimeoutCounter - 8'd1;
                    end
                end
                DECODE_INSTRUCTION: begin
                    leftOperandValue  <= regSValue;
                    rightOperandValue <= isImmediate ? extendedImmediate : regTValue;
                end
                COMPUTE_ALU_OPERATOR: begin
                    programCounter <= programCounter + 32'd4;
                end
                default: begin
                end
            endcase
        end
    end

    // Register contents survive reset; R0 is never written and reads as zero.
    always_ff @(posedge clock) begin
        if (reset && (state == COMPUTE_ALU_OPERATOR) && regWriteEnable) begin
            registerFile[destReg] <= aluResult;
        end
    end

    assign busWriteData = 32'h0;

    // Reserved inputs and architectural state kept for visibility only.
    logic unusedSignals;
    assign unusedSignals = ^{interrupts, processorStatusWordValue,
                             exceptionReturnAddressRegister, mmuAffectRandomIndexCounter};

endmodule

// File: tb/tb_eco32_cpu_core.sv
// Testbench for eco32_cpu_core: a table of instructions is fetched and
// executed in sequence, checking every pipeline step, then hand-written
// sequences cover reset during a fetch and the bus-timeout halt.
module tb_eco32_cpu_core;

    localparam logic [31:0] S_RESET     = 32'd0;
    localparam logic [31:0] S_BEGIN     = 32'd1;
    localparam logic [31:0] S_TRANSLATE = 32'd2;
    localparam logic [31:0] S_INTERPRET = 32'd3;
    localparam logic [31:0] S_FETCH     = 32'd4;
    localparam logic [31:0] S_DECODE    = 32'd5;
    localparam logic [31:0] S_COMPUTE   = 32'd6;
    localparam logic [31:0] S_HALT      = 32'd7;

    logic        clock;
    logic        reset;
    logic        busEnable;
    logic [1:0]  busSize;
    logic        busWrite;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;
    logic        busWait;
    logic [15:0] interrupts;

    int vectors;
    int miscompares;
    logic [31:0] pcModel;

    eco32_cpu_core dut (
        .clock        (clock),
        .reset        (reset),
        .busEnable    (busEnable),
        .busSize      (busSize),
        .busWrite     (busWrite),
        .busAddress   (busAddress),
        .busWriteData (busWriteData),
        .busReadData  (busReadData),
        .busWait      (busWait),
        .interrupts   (interrupts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        int          waits;
        logic        chkAlu;
        logic [31:0] expAlu;
        int          regIdx;
        logic [31:0] expReg;
    } vecType;

    vecType vecs [17];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Runs one instruction starting from a negedge in BEGIN_INSTRUCTION and
    // ends on the negedge of the following BEGIN_INSTRUCTION.
    task automatic runInstr(input int idx, input vecType v);
        logic [31:0] pc;
        logic [31:0] phys;
        pc   = pcModel;
        phys = (pc >= 32'hC0000000) ? (pc & 32'h3FFFFFFF) : pc;
        check("begin.state", 32'(dut.state), S_BEGIN);
        check("begin.pc", dut.programCounter, pc);
        @(negedge clock);
        check("translate.state", 32'(dut.state), S_TRANSLATE);
        check("translate.flag", 32'(dut.mmuAffectRandomIndexCounter), 32'd1);
        check("translate.era", dut.exceptionReturnAddressRegister, pc);
        check("translate.va", dut.virtualAddress, pc);
        @(negedge clock);
        check("interpret.state", 32'(dut.state), S_INTERPRET);
        check("interpret.flag", 32'(dut.mmuAffectRandomIndexCounter), 32'd0);
        busReadData = v.word;
        @(negedge clock);
        for (int k = 0; k <= v.waits; k++) begin
            check("fetch.state", 32'(dut.state), S_FETCH);
            check("fetch.enable", 32'(busEnable), 32'd1);
            check("fetch.address", busAddress, phys);
            check("fetch.size", 32'(busSize), 32'd2);
            check("fetch.write", 32'(busWrite), 32'd0);
            check("fetch.counter", 32'(dut.busTimeoutCounter), 32'(255 - k));
            busWait = (k < v.waits);
            @(negedge clock);
        end
        busWait = 1'b0;
        check("decode.state", 32'(dut.state), S_DECODE);
        check("decode.enable", 32'(busEnable), 32'd0);
        check("decode.ir", dut.currentInstruction, v.word);
        @(negedge clock);
        check("compute.state", 32'(dut.state), S_COMPUTE);
        if (v.chkAlu) check("compute.alu", dut.aluResult, v.expAlu);
        @(negedge clock);
        check("next.state", 32'(dut.state), S_BEGIN);
        check("next.pc", dut.programCounter, pc + 32'd4);
        check("next.psw", dut.processorStatusWordValue, 32'h0);
        check("next.reg", dut.registerFile[v.regIdx], v.expReg);
        pcModel = pc + 32'd4;
        $display("instr %0d pc=%08h word=%08h waits=%0d alu=%08h R%0d=%08h",
                 idx, pc, v.word, v.waits, v.expAlu, v.regIdx, dut.registerFile[v.regIdx]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        busWait     = 1'b0;
        busReadData = 32'h0;
        interrupts  = 16'h0;
        pcModel     = 32'hE0000000;

        //            word          waits chk  alu            reg  value
        vecs[0]  = '{32'h00000000, 0, 1'b1, 32'h00000000, 1,  32'hx};
        vecs[1]  = '{32'h04010042, 0, 1'b1, 32'h00000042, 1,  32'h00000042}; // ADDI r1,r0,42
        vecs[2]  = '{32'h4C04FFFF, 0, 1'b1, 32'h0000FFFF, 4,  32'h0000FFFF}; // ORI  r4,r0,FFFF
        vecs[3]  = '{32'h00211000, 2, 1'b1, 32'h00000084, 2,  32'h00000084}; // ADD  r2,r1,r1
        vecs[4]  = '{32'h0403FFFF, 0, 1'b1, 32'hFFFFFFFF, 3,  32'hFFFFFFFF}; // ADDI r3,r0,-1
        vecs[5]  = '{32'h04000005, 0, 1'b1, 32'h00000005, 1,  32'h00000042}; // ADDI r0,r0,5
        vecs[6]  = '{32'h08613000, 0, 1'b1, 32'hFFFFFFBD, 6,  32'hFFFFFFBD}; // SUB  r6,r3,r1
        vecs[7]  = '{32'h0C27FFFF, 1, 1'b1, 32'h00000043, 7,  32'h00000043}; // SUBI r7,r1,-1
        vecs[8]  = '{32'h40644000, 0, 1'b1, 32'h0000FFFF, 8,  32'h0000FFFF}; // AND  r8,r3,r4
        vecs[9]  = '{32'h44698001, 0, 1'b1, 32'h00008001, 9,  32'h00008001}; // ANDI r9,r3,8001
        vecs[10] = '{32'h546A00FF, 0, 1'b1, 32'hFFFFFF00, 10, 32'hFFFFFF00}; // XORI r10,r3,FF
        vecs[11] = '{32'h58245800, 0, 1'b1, 32'hFFFF0042, 11, 32'hFFFF0042}; // XNOR r11,r1,r4
        vecs[12] = '{32'h642C0004, 0, 1'b1, 32'h00000420, 12, 32'h00000420}; // SLLI r12,r1,4
        vecs[13] = '{32'h74CD0024, 0, 1'b1, 32'hFFFFFFFB, 13, 32'hFFFFFFFB}; // SARI r13,r6,24
        vecs[14] = '{32'h6CCE0004, 0, 1'b1, 32'h0FFFFFFB, 14, 32'h0FFFFFFB}; // SLRI r14,r6,4
        vecs[15] = '{32'hFC010000, 0, 1'b0, 32'h00000000, 1,  32'h00000042}; // undefined -> NOP
        vecs[16] = '{32'h60817800, 0, 1'b1, 32'h0003FFFC, 15, 32'h0003FFFC}; // SLL  r15,r4,r1

        // Reset held: everything in its reset state.
        repeat (3) @(negedge clock);
        check("reset.state", 32'(dut.state), S_RESET);
        check("reset.enable", 32'(busEnable), 32'd0);
        check("reset.write", 32'(busWrite), 32'd0);
        check("reset.size", 32'(busSize), 32'd2);
        check("reset.counter", 32'(dut.busTimeoutCounter), 32'h000000FF);
        check("reset.flag", 32'(dut.mmuAffectRandomIndexCounter), 32'd0);
        check("reset.pc", dut.programCounter, 32'hE0000000);
        check("reset.psw", dut.processorStatusWordValue, 32'h0);
        $display("reset held: state=%0d busEnable=%0d", dut.state, busEnable);

        reset = 1'b1;
        @(negedge clock);
        check("release.state", 32'(dut.state), S_BEGIN);
        check("release.flag", 32'(dut.mmuAffectRandomIndexCounter), 32'd0);
        check("release.data", busWriteData, 32'h0);

        // vecs[0] has no register expectation; check R1 only from vecs[1] on.
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                vecType v0;
                v0 = vecs[0];
                v0.regIdx = 0;
                v0.expReg = dut.registerFile[0];
                runInstr(i, v0);
                check("seq.nextaddr.pc", pcModel, 32'hE0000004);
            end else begin
                runInstr(i, vecs[i]);
            end
        end
        check("r1.unchanged", dut.registerFile[1], 32'h00000042);
        check("r2.kept", dut.registerFile[2], 32'h00000084);

        // Reset asserted in the middle of a stalled fetch.
        repeat (3) @(negedge clock);
        check("midfetch.state", 32'(dut.state), S_FETCH);
        busWait = 1'b1;
        reset   = 1'b0;
        @(negedge clock);
        check("midfetch.reset.state", 32'(dut.state), S_RESET);
        check("midfetch.reset.enable", 32'(busEnable), 32'd0);
        check("midfetch.reset.counter", 32'(dut.busTimeoutCounter), 32'h000000FF);
        busWait = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        check("midfetch.begin.state", 32'(dut.state), S_BEGIN);
        check("midfetch.begin.pc", dut.programCounter, 32'hE0000000);
        $display("reset during fetch: recovered to pc=%08h", dut.programCounter);

        // Bus timeout: busWait held until the counter is exhausted.
        repeat (3) @(negedge clock);
        busWait = 1'b1;
        repeat (255) @(negedge clock);
        check("timeout.last.state", 32'(dut.state), S_FETCH);
        check("timeout.last.counter", 32'(dut.busTimeoutCounter), 32'h0);
        check("timeout.last.enable", 32'(busEnable), 32'd1);
        @(negedge clock);
        check("timeout.halt.state", 32'(dut.state), S_HALT);
        check("timeout.halt.enable", 32'(busEnable), 32'd0);
        busWait = 1'b0;
        repeat (4) @(negedge clock);
        check("halt.stays.state", 32'(dut.state), S_HALT);
        check("halt.stays.enable", 32'(busEnable), 32'd0);
        $display("bus timeout: state=%0d busEnable=%0d", dut.state, busEnable);
        reset = 1'b0;
        @(negedge clock);
        check("halt.reset.state", 32'(dut.state), S_RESET);
        reset = 1'b1;
        @(negedge clock);
        check("halt.release.state", 32'(dut.state), S_BEGIN);
        check("halt.release.pc", dut.programCounter, 32'hE0000000);
        $display("recovery from halt: state=%0d", dut.state);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
